// File: rtl/ysyx_2022040010_stall_ctrl_if.sv
// ysyx_2022040010_stall_ctrl_if: stage request inputs and stall/redirect outputs of the pipeline sequencer
interface ysyx_2022040010_stall_ctrl_if #(
    parameter int STALL_W = 7,
    parameter int PC_W    = 64
);
    logic               if_busy;
    logic               mem_busy;
    logic               muldiv_busy;
    logic               load_use;
    logic               br_redirect;
    logic [PC_W-1:0]    br_target;
    logic [STALL_W-1:0] stall;
    logic               fetch_kill;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    modport master (
        output if_busy, mem_busy, muldiv_busy, load_use, br_redirect, br_target,
        input  stall, fetch_kill, redirect_valid, redirect_pc
    );
    modport slave (
        input  if_busy, mem_busy, muldiv_busy, load_use, br_redirect, br_target,
        output stall, fetch_kill, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_2022040010_stall_ctrl.sv
// ysyx_2022040010_stall_ctrl: pipeline stall/flush sequencer with redirect-vs-inflight-fetch handling
// Optional perf counters under YSYX_2022040010_STALL_PERF_EN.
module ysyx_2022040010_stall_ctrl #(
    parameter int STALL_W = 7,
    parameter int PC_W    = 64
) (
    input  logic clk,
    input  logic rst,
    ysyx_2022040010_stall_ctrl_if.slave bus
`ifdef YSYX_2022040010_STALL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);
    typedef enum logic {RUN, DROP} state_t;
    localparam logic [STALL_W-1:0] S_MEM   = STALL_W'(7'b1101011);
    localparam logic [STALL_W-1:0] S_MD    = STALL_W'(7'b0101011);
    localparam logic [STALL_W-1:0] S_FLUSH = STALL_W'(7'b0010100);
    localparam logic [STALL_W-1:0] S_LU    = STALL_W'(7'b0011011);
    localparam logic [STALL_W-1:0] S_IFB   = STALL_W'(7'b0000101);
    localparam logic [STALL_W-1:0] S_DROP  = STALL_W'(7'b0000111);
    state_t             state_q, state_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
    logic [STALL_W-1:0] s;
    logic               kill, accept, enter_drop;
    always_comb begin
        s                = '0;
        kill             = 1'b0;
        accept           = 1'b0;
        enter_drop       = 1'b0;
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = 1'b0;
        if (state_q == RUN) begin
            if (bus.mem_busy) s = S_MEM;
            else if (bus.muldiv_busy) s = S_MD;
            else if (bus.br_redirect) begin
                s             = S_FLUSH;
                redirect_pc_d = bus.br_target;
                accept        = 1'b1;
                if (bus.if_busy) begin
                    state_d    = DROP;
                    kill       = 1'b1;
                    enter_drop = 1'b1;
                end else redirect_valid_d = 1'b1;
            end
            else if (bus.load_use) s = S_LU;
            else if (bus.if_busy) s = S_IFB;
        end else begin
            kill = 1'b1;
            s    = bus.mem_busy ? S_DROP | S_MEM : bus.muldiv_busy ? S_DROP | S_MD :
                   bus.br_redirect ? S_DROP | S_FLUSH : S_DROP;
            if (!bus.mem_busy && !bus.muldiv_busy && bus.br_redirect) begin
                redirect_pc_d = bus.br_target;
                accept        = 1'b1;
            end
            if (!bus.if_busy) begin
                state_d          = RUN;
                redirect_valid_d = 1'b1;
            end
        end
        if (redirect_valid_q) s[2] = 1'b1;
        // a hold on a pipeline register always beats a bubble into it
        s[2] = s[2] & ~s[3];
        s[4] = s[4] & ~s[5];
        bus.stall      = rst ? s : '0;
        bus.fetch_kill = rst & kill;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
`ifdef YSYX_2022040010_STALL_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d, flush_cnt_q, flush_cnt_d, kill_cnt_q, kill_cnt_d;
    always_comb begin
        stall_cyc_d = stall_cyc_q + 32'((|bus.stall) && !(&stall_cyc_q));
        flush_cnt_d = flush_cnt_q + 32'(accept && !(&flush_cnt_q));
        kill_cnt_d  = kill_cnt_q + 32'(enter_drop && !(&kill_cnt_q));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end
    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;
`endif
endmodule

// File: tb/tb_ysyx_2022040010_stall_ctrl.sv
// tb_ysyx_2022040010_stall_ctrl: directed scenario tests for the pipeline stall sequencer
module tb_ysyx_2022040010_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    ysyx_2022040010_stall_ctrl_if #(.STALL_W(7), .PC_W(64)) bus ();
`ifdef YSYX_2022040010_STALL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_kill_cnt;
`endif
    ysyx_2022040010_stall_ctrl #(.STALL_W(7), .PC_W(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef YSYX_2022040010_STALL_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_kill_cnt(perf_kill_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.if_busy = 0; bus.mem_busy = 0; bus.muldiv_busy = 0;
        bus.load_use = 0; bus.br_redirect = 0; bus.br_target = '0;
    endtask
    task automatic test_reset();
        idle();
        #1;
        n_chk++; if (bus.stall !== 7'b0 || bus.fetch_kill !== 1'b0) $display("FAIL reset_init stall=%b kill=%b exp 0000000/0", bus.stall, bus.fetch_kill); else n_pass++;
        tick(); rst = 1'b1;
        bus.br_redirect = 1; bus.br_target = 64'h1234; bus.if_busy = 1;
        tick();
        bus.br_redirect = 0; #1;
        n_chk++; if (bus.fetch_kill !== 1'b1 || bus.stall !== 7'b0000111) $display("FAIL reset_in_drop kill=%b stall=%b exp 1/0000111", bus.fetch_kill, bus.stall); else n_pass++;
        #2 rst = 1'b0; #1;
        n_chk++; if (bus.stall !== 7'b0 || bus.fetch_kill !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 64'h0)
            $display("FAIL reset_async stall=%b kill=%b rv=%b pc=%h exp 0", bus.stall, bus.fetch_kill, bus.redirect_valid, bus.redirect_pc); else n_pass++;
        tick(); rst = 1'b1; #1;
        n_chk++; if (bus.fetch_kill !== 1'b0 || bus.stall !== 7'b0000101) $display("FAIL reset_run kill=%b stall=%b exp 0/0000101", bus.fetch_kill, bus.stall); else n_pass++;
        tick(); bus.if_busy = 0;
        tick();
        n_chk++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 64'h0) $display("FAIL reset_no_pulse rv=%b pc=%h exp 0/0", bus.redirect_valid, bus.redirect_pc); else n_pass++;
    endtask
    task automatic test_redirect_idle();
        idle(); bus.br_redirect = 1; bus.br_target = 64'h8000_0100; #1;
        n_chk++; if (bus.stall !== 7'b0010100 || bus.fetch_kill !== 1'b0) $display("FAIL idle_flush stall=%b kill=%b exp 0010100/0", bus.stall, bus.fetch_kill); else n_pass++;
        tick(); idle(); #1;
        n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h8000_0100) $display("FAIL idle_pulse rv=%b pc=%h exp 1/80000100", bus.redirect_valid, bus.redirect_pc); else n_pass++;
        n_chk++; if (bus.stall !== 7'b0000100) $display("FAIL idle_stale stall=%b exp 0000100", bus.stall); else n_pass++;
        tick();
        n_chk++; if (bus.redirect_valid !== 1'b0 || bus.stall !== 7'b0) $display("FAIL idle_after rv=%b stall=%b exp 0/0000000", bus.redirect_valid, bus.stall); else n_pass++;
    endtask
    task automatic test_redirect_busy();
        int kills = 0;
        int pulses = 0;
        idle(); bus.br_redirect = 1; bus.br_target = 64'h8000_0200; bus.if_busy = 1; #1;
        n_chk++; if (bus.stall !== 7'b0010100 || bus.fetch_kill !== 1'b1) $display("FAIL busy_enter stall=%b kill=%b exp 0010100/1", bus.stall, bus.fetch_kill); else n_pass++;
        kills += int'(bus.fetch_kill);
        for (int i = 0; i < 3; i++) begin
            tick(); bus.br_redirect = 0; bus.if_busy = (i < 2); #1;
            kills += int'(bus.fetch_kill);
            pulses += int'(bus.redirect_valid);
            n_chk++; if (bus.stall !== 7'b0000111) $display("FAIL busy_drop%0d stall=%b exp 0000111", i, bus.stall); else n_pass++;
        end
        tick(); #1;
        kills += int'(bus.fetch_kill);
        n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h8000_0200 || pulses != 0)
            $display("FAIL busy_pulse rv=%b pc=%h early=%0d exp 1/80000200/0", bus.redirect_valid, bus.redirect_pc, pulses); else n_pass++;
        n_chk++; if (kills != 4) $display("FAIL busy_kill_cycles got %0d exp 4", kills); else n_pass++;
        tick();
        n_chk++; if (bus.redirect_valid !== 1'b0 || bus.fetch_kill !== 1'b0) $display("FAIL busy_after rv=%b kill=%b exp 0/0", bus.redirect_valid, bus.fetch_kill); else n_pass++;
    endtask
    task automatic test_double_redirect();
        int pulses = 0;
        idle(); bus.br_redirect = 1; bus.br_target = 64'h100; bus.if_busy = 1;
        tick(); bus.br_target = 64'h200; #1;
        n_chk++; if (bus.stall !== 7'b0010111) $display("FAIL double_second stall=%b exp 0010111", bus.stall); else n_pass++;
        tick(); bus.br_redirect = 0; bus.if_busy = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(bus.redirect_valid);
        end
        n_chk++; if (pulses != 1 || bus.redirect_pc !== 64'h200) $display("FAIL double_result pulses=%0d pc=%h exp 1/200", pulses, bus.redirect_pc); else n_pass++;
    endtask
    task automatic test_concurrent();
        idle(); bus.load_use = 1; bus.mem_busy = 1; #1;
        n_chk++; if (bus.stall !== 7'b1101011) $display("FAIL conc_mem_lu stall=%b exp 1101011", bus.stall); else n_pass++;
        tick(); bus.mem_busy = 0; #1;
        n_chk++; if (bus.stall !== 7'b0011011) $display("FAIL conc_lu stall=%b exp 0011011", bus.stall); else n_pass++;
        tick(); bus.load_use = 0; bus.if_busy = 1; #1;
        n_chk++; if (bus.stall !== 7'b0000101) $display("FAIL conc_ifbusy stall=%b exp 0000101", bus.stall); else n_pass++;
        tick(); bus.load_use = 1; bus.br_redirect = 1; bus.if_busy = 0; bus.br_target = 64'h300; #1;
        n_chk++; if (bus.stall !== 7'b0010100) $display("FAIL conc_br_beats_lu stall=%b exp 0010100", bus.stall); else n_pass++;
        tick(); idle(); tick();
    endtask
    task automatic test_priority();
        logic [63:0] pc0;
        pc0 = bus.redirect_pc;
        idle(); bus.br_redirect = 1; bus.br_target = 64'hdead; bus.muldiv_busy = 1; #1;
        n_chk++; if (bus.stall !== 7'b0101011 || bus.fetch_kill !== 1'b0) $display("FAIL prio_md stall=%b kill=%b exp 0101011/0", bus.stall, bus.fetch_kill); else n_pass++;
        tick(); bus.muldiv_busy = 0; bus.mem_busy = 1; bus.if_busy = 1; #1;
        n_chk++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== pc0) $display("FAIL prio_md_ignored rv=%b pc=%h exp 0/%h", bus.redirect_valid, bus.redirect_pc, pc0); else n_pass++;
        n_chk++; if (bus.stall !== 7'b1101011 || bus.fetch_kill !== 1'b0) $display("FAIL prio_mem stall=%b kill=%b exp 1101011/0", bus.stall, bus.fetch_kill); else n_pass++;
        tick(); idle(); #1;
        n_chk++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== pc0) $display("FAIL prio_mem_ignored rv=%b pc=%h exp 0/%h", bus.redirect_valid, bus.redirect_pc, pc0); else n_pass++;
    endtask
    initial begin
        test_reset();
        test_redirect_idle();
        test_redirect_busy();
        test_double_redirect();
        test_concurrent();
        test_priority();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
